// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe
//   N-way operand select with a registered output stage, one skid entry and a
//   valid/ready handshake. Sits between register-read/forwarding and execute.
//   An out-of-range select captures all zeros and sets a sticky error flag.
//
// Parameters
//   WIDTH   data width per input and output
//   NUM_IN  number of selectable inputs (2..16)
//   SEL_W   select width, at least clog2(NUM_IN)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, drops all buffered beats
//   in_data      packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel       index of the input to capture
//   in_valid     upstream beat present
//   in_ready     block can accept a beat (registered)
//   out_data     selected operand (registered)
//   out_valid    out_data holds a valid beat
//   out_ready    downstream accepts out_data
//   sel_err      sticky: an out-of-range select was accepted
//   sel_err_cnt  (only with SEL_ERR_CNT_EN) saturating count of accepted
//                out-of-range selects
//
// Build option: define SEL_ERR_CNT_EN to add the sel_err_cnt port and counter.

module operand_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef SEL_ERR_CNT_EN
  ,
  output logic [7:0]              sel_err_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             accept;
  logic             emit;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic             sel_bad;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Out-of-range selects fall through with sel_hit low and zero data.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  // The skid entry is valid exactly when the state is FULL.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // A beat offered on a flush cycle is discarded, error included.
  assign sel_bad = accept & ~flush & ~sel_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      if (load_main_in) begin
        out_data <= sel_data;
      end else if (load_main_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= sel_data;
      end
      if (sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

`ifdef SEL_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_cnt <= '0;
    end else if (sel_bad && (sel_err_cnt != 8'hFF)) begin
      sel_err_cnt <= sel_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main DUT: default parameters.
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready, out_valid, out_ready, flush, sel_err;
  logic [31:0]  out_data;

  // Second DUT: NUM_IN=3 so that in_sel=3 is out of range.
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, flush3, sel_err3;
  logic [31:0]  out_data3;
`ifdef SEL_ERR_CNT_EN
  logic [7:0]   cnt_a, cnt_b;
`endif

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
`ifdef SEL_ERR_CNT_EN
    , .sel_err_cnt(cnt_a)
`endif
  );

  operand_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
`ifdef SEL_ERR_CNT_EN
    , .sel_err_cnt(cnt_b)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        rdy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic step3(input logic v, input logic [1:0] s, input logic fl);
    in_valid3  = v;
    in_sel3    = s;
    flush3     = fl;
    out_ready3 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic r);
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    flush     = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Expected values describe the outputs right after the edge the inputs are applied on.
    vecs.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'hCCCC0002, 1'b1, "single"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, "single_drain"});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, "stream0"});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'hBBBB0001, 1'b1, "stream1"});
    vecs.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'hCCCC0002, 1'b1, "stream2"});
    vecs.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hDDDD0003, 1'b1, "stream3"});
    vecs.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, "stream4"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, "stream_drain"});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'hBBBB0001, 1'b1, "stall_a"});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'hBBBB0001, 1'b0, "stall_b"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'hBBBB0001, 1'b0, "stall_hold"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'hDDDD0003, 1'b1, "stall_rel"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, "stall_drain"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'hCCCC0002, 1'b1, "full_a"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'hCCCC0002, 1'b0, "full_b"});
    vecs.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, "full_noacc"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, "full_drain"});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'hBBBB0001, 1'b1, "flf_a"});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'hBBBB0001, 1'b0, "flf_b"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, "flush_full"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, "fl1_a"});
    vecs.push_back('{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, "flush_one"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, "flush_after"});

    in_data  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_data3 = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_valid = 1'b0; in_sel = '0; out_ready = 1'b1; flush = 1'b0;
    in_valid3 = 1'b0; in_sel3 = '0; out_ready3 = 1'b1; flush3 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_sel_err",   {31'd0, sel_err},   32'd0);
`ifdef SEL_ERR_CNT_EN
    chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].v;
      in_sel    = vecs[i].sel;
      out_ready = vecs[i].rdy;
      flush     = vecs[i].fl;
      @(posedge clk); #1;
      chk({vecs[i].name, "_ov"}, {31'd0, out_valid}, {31'd0, vecs[i].ov});
      chk({vecs[i].name, "_ir"}, {31'd0, in_ready},  {31'd0, vecs[i].ir});
      if (vecs[i].ov) chk({vecs[i].name, "_od"}, out_data, vecs[i].od);
      chk({vecs[i].name, "_err"}, {31'd0, sel_err}, 32'd0);
    end
    flush = 1'b0;

    // Out-of-range selects on the 3-input instance.
    step3(1'b1, 2'd3, 1'b1);
    chk("oor_flush_err", {31'd0, sel_err3},   32'd0);
    chk("oor_flush_ov",  {31'd0, out_valid3}, 32'd0);
    step3(1'b1, 2'd3, 1'b0);
    chk("oor1_ov",  {31'd0, out_valid3}, 32'd1);
    chk("oor1_od",  out_data3,           32'd0);
    chk("oor1_err", {31'd0, sel_err3},   32'd1);
    step3(1'b1, 2'd1, 1'b0);
    chk("oor_legal_od",  out_data3,         32'hBBBB0001);
    chk("oor_legal_err", {31'd0, sel_err3}, 32'd1);
    step3(1'b1, 2'd3, 1'b0);
    chk("oor2_od", out_data3, 32'd0);
    step3(1'b1, 2'd3, 1'b0);
    step3(1'b1, 2'd2, 1'b0);
    chk("oor_last_od", out_data3, 32'hCCCC0002);
    step3(1'b0, 2'd0, 1'b0);
    chk("oor_idle_err", {31'd0, sel_err3},   32'd1);
    chk("oor_idle_ov",  {31'd0, out_valid3}, 32'd0);
`ifdef SEL_ERR_CNT_EN
    chk("oor_cnt", {24'd0, cnt_b}, 32'd3);
`endif

    // Asynchronous reset while the main instance is FULL.
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    chk("ar_full_ir", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ov",   {31'd0, out_valid},  32'd0);
    chk("ar_ir",   {31'd0, in_ready},   32'd1);
    chk("ar_od",   out_data,            32'd0);
    chk("ar_err3", {31'd0, sel_err3},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_rel_ov", {31'd0, out_valid}, 32'd0);
    step(1'b1, 2'd3, 1'b1);
    chk("ar_new_ov", {31'd0, out_valid}, 32'd1);
    chk("ar_new_od", out_data,           32'hDDDD0003);
    step(1'b0, 2'd0, 1'b1);
    chk("ar_drain_ov", {31'd0, out_valid}, 32'd0);
    chk("ar_drain_ir", {31'd0, in_ready},  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
